// File: rtl/clk_div_multi_if.sv
// rtl/clk_div_multi_if.sv - control and output bundle for clk_div_multi
// Macro CLK_DIV_TICK_EN adds the per-channel tick wrap pulse.
interface clk_div_multi_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
);
  logic              load;
  logic [SEL_W-1:0]  ch_sel;
  logic [WIDTH-1:0]  N;
  logic              sync;
  logic [NUM_CH-1:0] OutFreq;
  logic [NUM_CH-1:0] busy;
`ifdef CLK_DIV_TICK_EN
  logic [NUM_CH-1:0] tick;

  modport master (output load, ch_sel, N, sync, input OutFreq, busy, tick);
  modport slave  (input load, ch_sel, N, sync, output OutFreq, busy, tick);
`else
  modport master (output load, ch_sel, N, sync, input OutFreq, busy);
  modport slave  (input load, ch_sel, N, sync, output OutFreq, busy);
`endif
endinterface

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel glitch-free programmable clock divider
// Macro CLK_DIV_TICK_EN enables the per-channel tick wrap pulse output.
module clk_div_multi #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2
) (
  input  logic            RefClk,
  input  logic            reset,
  clk_div_multi_if.slave  bus
);

  logic [WIDTH-1:0]  shadow [NUM_CH];
  logic [WIDTH-1:0]  active [NUM_CH];
  logic [WIDTH-1:0]  count  [NUM_CH];
  logic [WIDTH-1:0]  act_n  [NUM_CH];
  logic [WIDTH-1:0]  cnt_n  [NUM_CH];
  logic [WIDTH:0]    half   [NUM_CH];
  logic [NUM_CH-1:0] pending, out_q;
  logic [NUM_CH-1:0] running, wrap, apply, run_n, out_n, hit;

  // Next-state is computed once here so the output register only ever sees
  // the count/divisor pair of the period it belongs to.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      running[i] = active[i] >= WIDTH'(2);
      wrap[i]    = running[i] && (count[i] == active[i] - WIDTH'(1));
      apply[i]   = pending[i] && (bus.sync || wrap[i] || !running[i]);
      act_n[i]   = apply[i] ? shadow[i] : active[i];
      run_n[i]   = act_n[i] >= WIDTH'(2);
      cnt_n[i]   = (bus.sync || wrap[i] || !running[i]) ? '0 : count[i] + WIDTH'(1);
      half[i]    = ({1'b0, act_n[i]} + (WIDTH+1)'(1)) >> 1;
      out_n[i]   = run_n[i] && ({1'b0, cnt_n[i]} < half[i]);
      hit[i]     = bus.load && (bus.ch_sel == SEL_W'(i));
    end
  end

  always_ff @(posedge RefClk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
        count[i]  <= '0;
      end
      pending <= '0;
      out_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        active[i] <= act_n[i];
        count[i]  <= cnt_n[i];
        out_q[i]  <= out_n[i];
        // A load coinciding with an apply keeps pending set for the new value.
        if (hit[i]) begin
          shadow[i]  <= bus.N;
          pending[i] <= 1'b1;
        end else if (apply[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.OutFreq = out_q;
  assign bus.busy    = pending;

`ifdef CLK_DIV_TICK_EN
  logic [NUM_CH-1:0] tick_q;

  always_ff @(posedge RefClk or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
    end else begin
      tick_q <= running & (wrap | {NUM_CH{bus.sync}}) & run_n;
    end
  end

  assign bus.tick = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
// Uses NUM_CH=3 so ch_sel=3 exercises the out-of-range path.
module tb_clk_div_multi;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 3;
  localparam int SEL_W  = 2;

  logic RefClk = 1'b0;
  logic reset  = 1'b1;
  int   npass  = 0;
  int   ntotal = 0;

  clk_div_multi_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus ();

  clk_div_multi #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) dut (
    .RefClk (RefClk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 RefClk = ~RefClk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge RefClk);
    @(negedge RefClk);
  endtask

  task automatic do_reset();
    bus.load = 1'b0; bus.sync = 1'b0; bus.ch_sel = '0; bus.N = '0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_load(input int ch, input int n);
    bus.load = 1'b1; bus.ch_sel = SEL_W'(ch); bus.N = WIDTH'(n);
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    bus.load = 1'b0; bus.sync = 1'b0; bus.ch_sel = '0; bus.N = '0;
    reset = 1'b1;
    cyc();
    ntotal++;
    if (bus.OutFreq !== 3'b000) $display("FAIL reset_out: got %b expected 000", bus.OutFreq);
    else npass++;
    ntotal++;
    if (bus.busy !== 3'b000) $display("FAIL reset_busy: got %b expected 000", bus.busy);
    else npass++;
    reset = 1'b0;
    cyc(); cyc();
    ntotal++;
    if ({bus.OutFreq, bus.busy} !== 6'b0) $display("FAIL idle_after_reset: got %b expected 000000", {bus.OutFreq, bus.busy});
    else npass++;
  endtask

  task automatic test_load_n4();
    logic [6:0] pat = 7'b1001100;  // E2..E8, msb first
    do_reset();
    do_load(0, 4);
    ntotal++;
    if ({bus.busy[0], bus.OutFreq[0]} !== 2'b10) $display("FAIL n4_e0: got %b expected 10", {bus.busy[0], bus.OutFreq[0]});
    else npass++;
    cyc();
    ntotal++;
    if ({bus.busy[0], bus.OutFreq[0]} !== 2'b01) $display("FAIL n4_e1: got %b expected 01", {bus.busy[0], bus.OutFreq[0]});
    else npass++;
    for (int k = 0; k < 7; k++) begin
      cyc();
      ntotal++;
      if (bus.OutFreq[0] !== pat[6-k]) $display("FAIL n4_pattern[%0d]: got %b expected %b", k, bus.OutFreq[0], pat[6-k]);
      else npass++;
    end
  endtask

  task automatic test_load_n5();
    logic [1:0] exp_v [10] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
    do_reset();
    do_load(0, 4);
    do_load(1, 5);
    for (int k = 0; k < 10; k++) begin
      cyc();
      ntotal++;
      if (bus.OutFreq[1:0] !== exp_v[k]) $display("FAIL n5_ch1_ch0[%0d]: got %b expected %b", k, bus.OutFreq[1:0], exp_v[k]);
      else npass++;
    end
  endtask

  task automatic test_reload_mid();
    // {busy[0], OutFreq[0]} for E3..E11 after reloading N=6 at E2
    logic [1:0] exp_v [9] = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1};
    do_reset();
    do_load(0, 4);
    cyc();
    do_load(0, 6);
    ntotal++;
    if ({bus.busy[0], bus.OutFreq[0]} !== 2'b11) $display("FAIL reload_e2: got %b expected 11", {bus.busy[0], bus.OutFreq[0]});
    else npass++;
    for (int k = 0; k < 9; k++) begin
      cyc();
      ntotal++;
      if ({bus.busy[0], bus.OutFreq[0]} !== exp_v[k]) $display("FAIL reload_seq[%0d]: got %b expected %b", k, {bus.busy[0], bus.OutFreq[0]}, exp_v[k]);
      else npass++;
    end
  endtask

  task automatic test_stop_restart();
    logic [3:0] tog = 4'b1010;
    do_reset();
    do_load(2, 4);
    cyc();
    do_load(2, 1);
    ntotal++;
    if (bus.OutFreq[2] !== 1'b1) $display("FAIL stop_e2: got %b expected 1", bus.OutFreq[2]);
    else npass++;
    cyc(); cyc(); cyc();
    for (int k = 0; k < 3; k++) begin
      ntotal++;
      if ({bus.busy[2], bus.OutFreq[2]} !== 2'b00) $display("FAIL stopped[%0d]: got %b expected 00", k, {bus.busy[2], bus.OutFreq[2]});
      else npass++;
      if (k < 2) cyc();
    end
    do_load(2, 2);
    ntotal++;
    if ({bus.busy[2], bus.OutFreq[2]} !== 2'b10) $display("FAIL restart_load: got %b expected 10", {bus.busy[2], bus.OutFreq[2]});
    else npass++;
    for (int k = 0; k < 4; k++) begin
      cyc();
      ntotal++;
      if (bus.OutFreq[2] !== tog[3-k]) $display("FAIL n2_toggle[%0d]: got %b expected %b", k, bus.OutFreq[2], tog[3-k]);
      else npass++;
    end
  endtask

  task automatic test_sync();
    // {busy[1], OutFreq[1]} for E10..E24; ch1 reloaded to 8 alongside sync
    logic [1:0] exp_v [15] = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1,
                               2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    do_reset();
    do_load(0, 4);
    do_load(1, 7);
    do_load(2, 10);
    for (int k = 0; k < 6; k++) cyc();
    ntotal++;
    if (bus.OutFreq !== 3'b000) $display("FAIL pre_sync: got %b expected 000", bus.OutFreq);
    else npass++;
    bus.sync = 1'b1;
    do_load(1, 8);
    bus.sync = 1'b0;
    ntotal++;
    if (bus.OutFreq !== 3'b111) $display("FAIL sync_align: got %b expected 111", bus.OutFreq);
    else npass++;
    ntotal++;
    if (bus.busy !== 3'b010) $display("FAIL sync_busy: got %b expected 010", bus.busy);
    else npass++;
    for (int k = 0; k < 15; k++) begin
      cyc();
      ntotal++;
      if ({bus.busy[1], bus.OutFreq[1]} !== exp_v[k]) $display("FAIL sync_ch1[%0d]: got %b expected %b", k, {bus.busy[1], bus.OutFreq[1]}, exp_v[k]);
      else npass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_load(0, 4);
    cyc();
    do_load(0, 6);
    ntotal++;
    if ({bus.busy[0], bus.OutFreq[0]} !== 2'b11) $display("FAIL pre_areset: got %b expected 11", {bus.busy[0], bus.OutFreq[0]});
    else npass++;
    #1 reset = 1'b1;
    #1;
    ntotal++;
    if ({bus.OutFreq, bus.busy} !== 6'b0) $display("FAIL async_reset: got %b expected 000000", {bus.OutFreq, bus.busy});
    else npass++;
    @(negedge RefClk);
    reset = 1'b0;
    cyc(); cyc(); cyc();
    ntotal++;
    if ({bus.OutFreq, bus.busy} !== 6'b0) $display("FAIL divisor_lost: got %b expected 000000", {bus.OutFreq, bus.busy});
    else npass++;
  endtask

  task automatic test_out_of_range();
    do_reset();
    do_load(3, 4);
    ntotal++;
    if (bus.busy !== 3'b000) $display("FAIL oor_busy: got %b expected 000", bus.busy);
    else npass++;
    cyc(); cyc();
    ntotal++;
    if (bus.OutFreq !== 3'b000) $display("FAIL oor_out: got %b expected 000", bus.OutFreq);
    else npass++;
  endtask

`ifdef CLK_DIV_TICK_EN
  task automatic test_tick();
    logic [12:0] pat = 13'b0000100010001;  // E1..E13, msb first
    do_reset();
    do_load(0, 4);
    for (int k = 0; k < 13; k++) begin
      cyc();
      ntotal++;
      if (bus.tick[0] !== pat[12-k]) $display("FAIL tick0[%0d]: got %b expected %b", k, bus.tick[0], pat[12-k]);
      else npass++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_n4();
    test_load_n5();
    test_reload_mid();
    test_stop_restart();
    test_sync();
    test_async_reset();
    test_out_of_range();
`ifdef CLK_DIV_TICK_EN
    test_tick();
`endif
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
